// File: rtl/hs_pkg.sv
// Shared types and defaults for the 4-phase req/ack source-side controller.
package hs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } hs_state_t;

  localparam int HS_TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/synch_ff2.sv
// Two-flop synchronizer bringing an asynchronous signal into the clk domain.
module synch_ff2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hs_tx_ctrl.sv
// Source-side 4-phase req/ack controller: holds one word on tx_data per transfer.
// Define HS_TIMEOUT_EN to enable the sticky err_timeout watchdog; otherwise it is tied low.
module hs_tx_ctrl
  import hs_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = HS_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             tx_req,
  output logic [WIDTH-1:0] tx_data,
  input  logic             rx_ack,
  output logic             busy,
  output logic             err_timeout
);

  hs_state_t state;
  logic      ack_s;
  logic      accept;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("hs_tx_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  synch_ff2 #(.WIDTH(1)) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_ack),
    .q     (ack_s)
  );

  assign accept = (state == IDLE) && in_valid && in_ready;
  assign busy   = (state != IDLE);

  // in_ready is registered and only rises once the FSM is back in IDLE,
  // so a second word can never be taken while one is still in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx_req   <= 1'b0;
      tx_data  <= '0;
      in_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            tx_data  <= in_data;
            tx_req   <= 1'b1;
            in_ready <= 1'b0;
            state    <= REQ;
          end else begin
            in_ready <= 1'b1;
          end
        end
        REQ: begin
          if (ack_s) begin
            tx_req <= 1'b0;
            state  <= REL;
          end
        end
        REL: begin
          if (!ack_s) begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: begin
          tx_req   <= 1'b0;
          in_ready <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef HS_TIMEOUT_EN
  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             leaving;

  assign leaving = ((state == REQ) && ack_s) || ((state == REL) && !ack_s);
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  // Counter restarts on every state change; the FSM itself never aborts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else if ((state == IDLE) || leaving) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_inc;
      if (cnt_inc == CNT_MAX) begin
        err_timeout <= 1'b1;
      end
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hs_tx_ctrl.sv
// Randomized and directed bench for hs_tx_ctrl against a transfer-level reference model.
module tb_hs_tx_ctrl;

  localparam int WIDTH = 8;
  localparam int TO    = 64;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             tx_req;
  logic [WIDTH-1:0] tx_data;
  logic             rx_ack = 1'b0;
  logic             busy;
  logic             err_timeout;

  int n_chk = 0;
  int n_err = 0;

  hs_tx_ctrl #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .tx_req      (tx_req),
    .tx_data     (tx_data),
    .rx_ack      (rx_ack),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 = waiting for a word, 1 = request outstanding,
  // 2 = request withdrawn, waiting for the ack to go away.
  int               m_phase;
  logic             m_ready, m_req, m_err, m_acc;
  logic [WIDTH-1:0] m_data;
  int               m_tcnt;
  logic             ackq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_ready = 1'b0; m_req = 1'b0; m_err = 1'b0; m_acc = 1'b0;
    m_data = '0; m_tcnt = 0;
    ackq.delete();
  endtask

  task automatic model_edge();
    logic seen;
    int   prev;
    // The controller sees the ack as it was sampled two edges ago.
    seen = (ackq.size() >= 2) ? ackq[ackq.size()-2] : 1'b0;
    ackq.push_back(rx_ack);
    if (ackq.size() > 4) void'(ackq.pop_front());
    prev  = m_phase;
    m_acc = 1'b0;
    if (m_phase == 0) begin
      if (in_valid && m_ready) begin
        m_data = in_data; m_req = 1'b1; m_ready = 1'b0; m_phase = 1; m_acc = 1'b1;
      end else m_ready = 1'b1;
    end else if (m_phase == 1) begin
      if (seen) begin m_req = 1'b0; m_phase = 2; end
    end else begin
      if (!seen) begin m_ready = 1'b1; m_phase = 0; end
    end
`ifdef HS_TIMEOUT_EN
    if (m_phase == 0 || m_phase != prev) m_tcnt = 0;
    else begin
      if (m_tcnt < TO) m_tcnt++;
      if (m_tcnt >= TO) m_err = 1'b1;
    end
`else
    prev = prev;
`endif
  endtask

  task automatic check_all();
    chk("in_ready", in_ready, m_ready);
    chk("tx_req", tx_req, m_req);
    chk("tx_data", tx_data, m_data);
    chk("busy", busy, (m_phase != 0));
    chk("err_timeout", err_timeout, m_err);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; rx_ack = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_tx_req", tx_req, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Finish the current transfer acting as a well-behaved destination.
  task automatic complete_handshake(input string tag);
    int i;
    rx_ack = 1'b1;
    for (i = 0; i < 20 && tx_req; i++) step();
    chk({tag, "_req_drop"}, tx_req, 0);
    rx_ack = 1'b0;
    for (i = 0; i < 20 && !in_ready; i++) step();
    chk({tag, "_ready_back"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int dly;
    model_reset();
    // Reset state and first cycle after release
    do_reset();
    step();
    chk("t1_ready", in_ready, 1);
    chk("t1_req", tx_req, 0);
    chk("t1_data", tx_data, 0);
    chk("t1_busy", busy, 0);

    // Single transfer of A5 with a stalled 3C behind it
    in_valid = 1'b1; in_data = 8'hA5;
    step();                                   // edge N
    chk("t2_req_up", tx_req, 1);
    chk("t2_data", tx_data, 8'hA5);
    in_data = 8'h3C;                          // held through REQ/REL
    step(); step();                           // N+1, N+2
    rx_ack = 1'b1;
    step(); step();                           // N+3, N+4
    chk("t2_req_still", tx_req, 1);
    step();                                   // N+5
    chk("t2_req_down", tx_req, 0);
    step();                                   // N+6
    rx_ack = 1'b0;
    step(); step();                           // N+7, N+8
    chk("t3_not_ready", in_ready, 0);
    chk("t3_data_hold", tx_data, 8'hA5);
    step();                                   // N+9
    chk("t2_ready_back", in_ready, 1);
    chk("t3_data_still", tx_data, 8'hA5);
    step();                                   // N+10
    chk("t3_accept_3c", tx_data, 8'h3C);
    chk("t3_req_3c", tx_req, 1);
    in_valid = 1'b0;
    complete_handshake("t3");

    // Spurious one-cycle ack in IDLE
    rx_ack = 1'b1;
    step();
    rx_ack = 1'b0;
    repeat (5) step();
    chk("t4_req", tx_req, 0);
    chk("t4_busy", busy, 0);
    chk("t4_ready", in_ready, 1);
    chk("t4_data", tx_data, 8'h3C);

    // Reset during REQ
    in_valid = 1'b1; in_data = 8'h77;
    step();                                   // N
    in_valid = 1'b0;
    repeat (3) step();                        // N+1..N+3
    chk("t5_req_before", tx_req, 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_req_async", tx_req, 0);
    chk("t5_busy_async", busy, 0);
    do_reset();
    step();
    in_valid = 1'b1; in_data = 8'h11;
    step();
    chk("t5_accept_11", tx_data, 8'h11);
    chk("t5_req_11", tx_req, 1);
    in_valid = 1'b0;
    complete_handshake("t5");

    // Randomized traffic with a destination of random latency
    dly = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      step();
      if (!in_valid || m_acc) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_data  = WIDTH'($urandom);
      end
      if (dly > 0) dly--;
      else if (tx_req && !rx_ack) begin rx_ack = 1'b1; dly = $urandom_range(0, 5); end
      else if (!tx_req && rx_ack) begin rx_ack = 1'b0; dly = $urandom_range(0, 5); end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 40 && (busy || rx_ack); i++) begin
      step();
      if (tx_req) rx_ack = 1'b1;
      else rx_ack = 1'b0;
    end
    chk("rand_idle", busy, 0);

    // Handshake that never completes: watchdog behaviour
    do_reset();
    step();
    in_valid = 1'b1; in_data = 8'hC3;
    step();                                   // entry to REQ
    in_valid = 1'b0;
    repeat (TO - 1) step();
    chk("t6_err_before", err_timeout, 0);
    step();
`ifdef HS_TIMEOUT_EN
    chk("t6_err_set", err_timeout, 1);
    repeat (10) step();
    chk("t6_err_sticky", err_timeout, 1);
`else
    chk("t6_err_off", err_timeout, 0);
    repeat (10) step();
    chk("t6_err_off_late", err_timeout, 0);
`endif
    chk("t6_still_req", tx_req, 1);
    do_reset();
    step();
    chk("t6_err_cleared", err_timeout, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
